// File: rtl/mtl_scan_timing.sv
// Raster timing generator and output alignment for the MTL 800x480 panel.
// Produces live x/y counters for the renderers and re-aligns sync/DE to the renderer RGB.
module mtl_scan_timing #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 48,
    parameter int H_BP     = 168,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 13,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 29,
    parameter int PIPE_DLY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic [10:0] x_cnt,
    output logic [9:0]  y_cnt,
    output logic        frame_start,
    output logic [7:0]  frame_cnt,
    input  logic [7:0]  red_in,
    input  logic [7:0]  green_in,
    input  logic [7:0]  blue_in,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        de,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT_W  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT_W  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [10:0] x_cnt_reg, x_next;
    logic [9:0]  y_cnt_reg, y_next;
    logic [7:0]  frame_cnt_reg, frame_next;

    logic line_end, frame_end, scanning;
    logic de_raw, hs_raw, vs_raw;

    assign line_end  = (x_cnt_reg == H_LAST);
    assign frame_end = line_end && (y_cnt_reg == V_LAST);
    assign scanning  = (state_reg != IDLE);

    always_comb begin
        state_next = state_reg;
        x_next     = x_cnt_reg;
        y_next     = y_cnt_reg;
        frame_next = frame_cnt_reg;
        case (state_reg)
            IDLE: begin
                x_next = '0;
                y_next = '0;
                if (run) begin
                    state_next = RUN;
                end
            end
            RUN, STOP: begin
                if (line_end) begin
                    x_next = '0;
                    if (frame_end) begin
                        y_next     = '0;
                        frame_next = frame_cnt_reg + 8'd1;
                    end else begin
                        y_next = y_cnt_reg + 10'd1;
                    end
                end else begin
                    x_next = x_cnt_reg + 11'd1;
                end
                // A stop request only takes effect once the frame has been fully scanned.
                if (state_reg == RUN) begin
                    if (!run) begin
                        state_next = STOP;
                    end
                end else if (run) begin
                    state_next = RUN;
                end else if (frame_end) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                x_next     = '0;
                y_next     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            x_cnt_reg     <= '0;
            y_cnt_reg     <= '0;
            frame_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            x_cnt_reg     <= x_next;
            y_cnt_reg     <= y_next;
            frame_cnt_reg <= frame_next;
        end
    end

    assign x_cnt       = x_cnt_reg;
    assign y_cnt       = y_cnt_reg;
    assign frame_cnt   = frame_cnt_reg;
    assign frame_start = (state_reg == RUN) && (x_cnt_reg == '0) && (y_cnt_reg == '0);

    assign de_raw = scanning && (x_cnt_reg < H_ACT_W) && (y_cnt_reg < V_ACT_W);
    assign hs_raw = scanning && (x_cnt_reg >= HS_START) && (x_cnt_reg < HS_END);
    assign vs_raw = scanning && (y_cnt_reg >= VS_START) && (y_cnt_reg < VS_END);

    // Delay line matching the renderer latency; stage PIPE_DLY-1 lines up with red_in/green_in/blue_in.
    logic [PIPE_DLY-1:0] de_pipe_reg, hs_pipe_reg, vs_pipe_reg;

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_DLY; gi++) begin : g_dly
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        de_pipe_reg[gi] <= 1'b0;
                        hs_pipe_reg[gi] <= 1'b0;
                        vs_pipe_reg[gi] <= 1'b0;
                    end else begin
                        de_pipe_reg[gi] <= de_raw;
                        hs_pipe_reg[gi] <= hs_raw;
                        vs_pipe_reg[gi] <= vs_raw;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        de_pipe_reg[gi] <= 1'b0;
                        hs_pipe_reg[gi] <= 1'b0;
                        vs_pipe_reg[gi] <= 1'b0;
                    end else begin
                        de_pipe_reg[gi] <= de_pipe_reg[gi-1];
                        hs_pipe_reg[gi] <= hs_pipe_reg[gi-1];
                        vs_pipe_reg[gi] <= vs_pipe_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    logic de_d, hs_d, vs_d;
    assign de_d = de_pipe_reg[PIPE_DLY-1];
    assign hs_d = hs_pipe_reg[PIPE_DLY-1];
    assign vs_d = vs_pipe_reg[PIPE_DLY-1];

    logic       de_reg, hsync_n_reg, vsync_n_reg;
    logic [7:0] red_reg, green_reg, blue_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_reg      <= 1'b0;
            hsync_n_reg <= 1'b1;
            vsync_n_reg <= 1'b1;
            red_reg     <= '0;
            green_reg   <= '0;
            blue_reg    <= '0;
        end else begin
            de_reg      <= de_d;
            hsync_n_reg <= ~hs_d;
            vsync_n_reg <= ~vs_d;
            red_reg     <= de_d ? red_in   : 8'd0;
            green_reg   <= de_d ? green_in : 8'd0;
            blue_reg    <= de_d ? blue_in  : 8'd0;
        end
    end

    assign de      = de_reg;
    assign hsync_n = hsync_n_reg;
    assign vsync_n = vsync_n_reg;
    assign red     = red_reg;
    assign green   = green_reg;
    assign blue    = blue_reg;

endmodule

// File: tb/tb_mtl_scan_timing.sv
// Bench for mtl_scan_timing on a shrunken raster: randomized run/RGB, reference model feeding a scoreboard.
module tb_mtl_scan_timing;

    localparam int HA = 16, HF = 4, HS = 5, HB = 7;
    localparam int VA = 10, VF = 2, VS = 2, VB = 3;
    localparam int PD = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [10:0] x_cnt;
    logic [9:0]  y_cnt;
    logic        frame_start;
    logic [7:0]  frame_cnt;
    logic [7:0]  red_in, green_in, blue_in;
    logic        hsync_n, vsync_n, de;
    logic [7:0]  red, green, blue;

    mtl_scan_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIPE_DLY(PD)
    ) dut (
        .clk(clk), .reset(reset), .run(run),
        .x_cnt(x_cnt), .y_cnt(y_cnt), .frame_start(frame_start), .frame_cnt(frame_cnt),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .hsync_n(hsync_n), .vsync_n(vsync_n), .de(de),
        .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x, y, fc, r, g, b;
        bit fs, de, hs_n, vs_n;
    } exp_t;
    typedef struct {
        bit de, hs, vs;
    } raw_t;

    exp_t exp_q[$];
    raw_t hist[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: a scanning/stopping pair of flags plus pixel position.
    bit   m_scan, m_stop;
    int   mx, my, mfc;
    logic run_ap, rst_ap;
    logic [7:0] r_ap, g_ap, b_ap;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    function automatic raw_t decode();
        raw_t r;
        r.de = m_scan && (mx < HA) && (my < VA);
        r.hs = m_scan && (mx >= HA + HF) && (mx < HA + HF + HS);
        r.vs = m_scan && (my >= VA + VF) && (my < VA + VF + VS);
        return r;
    endfunction

    task automatic model_reset();
        raw_t z;
        z = '{de: 1'b0, hs: 1'b0, vs: 1'b0};
        m_scan = 0; m_stop = 0; mx = 0; my = 0; mfc = 0;
        hist.delete();
        for (int i = 0; i < PD + 2; i++) hist.push_back(z);
    endtask

    // Advance the model across the clock edge that just passed, then queue what the pins must show.
    task automatic model_step();
        exp_t e;
        raw_t p;
        if (rst_ap) begin
            model_reset();
        end else begin
            if (!m_scan) begin
                if (run_ap) begin
                    m_scan = 1;
                    m_stop = 0;
                end
            end else if (mx == HT - 1 && my == VT - 1 && m_stop && !run_ap) begin
                m_scan = 0; mx = 0; my = 0; mfc = (mfc + 1) % 256;
            end else begin
                mx++;
                if (mx == HT) begin
                    mx = 0;
                    my++;
                    if (my == VT) begin
                        my = 0;
                        mfc = (mfc + 1) % 256;
                    end
                end
                m_stop = !run_ap;
            end
            hist.push_back(decode());
            void'(hist.pop_front());
        end
        p      = hist[0];
        e.x    = mx;
        e.y    = my;
        e.fc   = mfc;
        e.fs   = m_scan && !m_stop && mx == 0 && my == 0;
        e.de   = p.de;
        e.hs_n = !p.hs;
        e.vs_n = !p.vs;
        e.r    = p.de ? int'(r_ap) : 0;
        e.g    = p.de ? int'(g_ap) : 0;
        e.b    = p.de ? int'(b_ap) : 0;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic rst_v, input logic run_v, input bit ff_rgb);
        @(negedge clk);
        cyc++;
        model_step();
        reset    = rst_v;
        run      = run_v;
        red_in   = ff_rgb ? 8'hFF : 8'($urandom);
        green_in = ff_rgb ? 8'hFF : 8'($urandom);
        blue_in  = ff_rgb ? 8'hFF : 8'($urandom);
        rst_ap   = rst_v;
        run_ap   = run_v;
        r_ap     = red_in;
        g_ap     = green_in;
        b_ap     = blue_in;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("x_cnt", int'(x_cnt), e.x);
                check("y_cnt", int'(y_cnt), e.y);
                check("frame_start", int'(frame_start), int'(e.fs));
                check("frame_cnt", int'(frame_cnt), e.fc);
                check("de", int'(de), int'(e.de));
                check("hsync_n", int'(hsync_n), int'(e.hs_n));
                check("vsync_n", int'(vsync_n), int'(e.vs_n));
                check("red", int'(red), e.r);
                check("green", int'(green), e.g);
                check("blue", int'(blue), e.b);
            end
        end
    end

    initial begin : driver
        bit run_v;
        reset = 1'b1; run = 1'b1;
        red_in = '0; green_in = '0; blue_in = '0;
        rst_ap = 1'b1; run_ap = 1'b1;
        r_ap = '0; g_ap = '0; b_ap = '0;
        model_reset();

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
        // Two full frames plus a partial one; first frame with saturated white input.
        for (int i = 0; i < HT * VT; i++) cycle(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < HT * VT + 200; i++) cycle(1'b0, 1'b1, 1'b0);
        // Stop mid-frame, let it park in idle, then restart.
        for (int i = 0; i < HT * VT + 100; i++) cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 1'b0);
        // Brief stop request cancelled inside the same frame.
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < HT * VT; i++) cycle(1'b0, 1'b1, 1'b0);
        // Sparse random run toggling over several frames.
        run_v = 1'b1;
        for (int i = 0; i < 5 * HT * VT; i++) begin
            if ($urandom_range(0, 299) == 0) run_v = !run_v;
            cycle(1'b0, run_v, $urandom_range(0, 3) == 0);
        end
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 1'b0);
        while (!(my > 3 && my < VA && mx > 2 && mx < HA)) cycle(1'b0, 1'b1, 1'b0);

        // Asynchronous reset between clock edges: pins must clear without waiting for a clock.
        #2 reset = 1'b1;
        #1;
        check("async_x_cnt", int'(x_cnt), 0);
        check("async_y_cnt", int'(y_cnt), 0);
        check("async_frame_cnt", int'(frame_cnt), 0);
        check("async_frame_start", int'(frame_start), 0);
        check("async_de", int'(de), 0);
        check("async_hsync_n", int'(hsync_n), 1);
        check("async_vsync_n", int'(vsync_n), 1);
        check("async_rgb", int'({red, green, blue}), 0);
        rst_ap = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 400; i++) cycle(1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #3;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mtl_scan_timing.md
Name: mtl_scan_timing

Overview:
- Pixel-timing and output-alignment stage for the MTL 800x480 panel. Sits directly upstream and downstream of the cube/sprite renderers.
- Generates the raster counters x_cnt/y_cnt that the renderers consume.
- Delays sync/data-enable to match renderer pipeline latency.
- Gates the renderer RGB to black outside the active area and drives the panel pins.
- Includes a run/stop controller that starts and stops scanning on frame boundaries.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 48, hsync pulse width (clocks)
- H_BP, 168, horizontal back porch (clocks); H_TOTAL = sum = 1056
- V_ACTIVE, 480, visible lines per frame
- V_FP, 13, vertical front porch (lines)
- V_SYNC, 3, vsync pulse width (lines)
- V_BP, 29, vertical back porch (lines); V_TOTAL = sum = 525
- PIPE_DLY, 2, renderer latency in clocks from x_cnt/y_cnt to valid RGB; legal range >= 1

Ports:
- clk  in  1  pixel clock; one pixel per cycle
- reset  in  1  asynchronous, active-high
- run  in  1  level; 1 = scan frames, 0 = stop at the next frame end
- x_cnt  out  11  live horizontal counter, 0..H_TOTAL-1
- y_cnt  out  10  live vertical counter, 0..V_TOTAL-1
- frame_start  out  1  one-cycle pulse while the counters are at (0,0) in RUN
- frame_cnt  out  8  completed-frame counter, wraps 255 -> 0
- red_in, green_in, blue_in  in  8 each  renderer colour, valid PIPE_DLY clocks after the counters
- hsync_n, vsync_n  out  1 each  panel syncs, active-low, aligned to RGB out
- de  out  1  panel data enable, aligned to RGB out
- red, green, blue  out  8 each  panel colour

Behaviour:
- Clock and reset: one clock is used, clk. Reset is asynchronous and active-high on port reset; it clears all state immediately, including mid-frame.
- Reset values:
  - state = IDLE
  - x_cnt = 0, y_cnt = 0
  - frame_start = 0, frame_cnt = 0
  - all delay stages: de = 0, sync = inactive
  - hsync_n = 1, vsync_n = 1, de = 0
  - red = green = blue = 0
- State IDLE:
  - Counters held at (0,0).
  - Raw de forced 0; raw syncs forced inactive.
  - run = 1 -> RUN.
- State RUN:
  - x_cnt increments every clock.
  - At x_cnt = H_TOTAL-1: x_cnt -> 0 and y_cnt increments.
  - At (H_TOTAL-1, V_TOTAL-1): both counters -> 0 and frame_cnt increments.
  - run = 0 -> STOP.
- State STOP:
  - Counting continues exactly as in RUN.
  - run = 1 -> RUN, with no counter disturbance.
  - At (H_TOTAL-1, V_TOTAL-1) with run = 0: counters -> (0,0), frame_cnt increments, state -> IDLE.
- Start timing: the first cycle in RUN shows counters (0,0). frame_start is asserted combinationally from (state == RUN and x_cnt == 0 and y_cnt == 0). frame_start is not asserted in STOP or IDLE.
- Raw timing, decoded from the live counters:
  - de_raw = (x_cnt < H_ACTIVE) and (y_cnt < V_ACTIVE), in RUN/STOP only.
  - hs_raw active when H_ACTIVE+H_FP <= x_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw active when V_ACTIVE+V_FP <= y_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines.
- Alignment pipeline:
  - de_raw, hs_raw and vs_raw pass through PIPE_DLY register stages clocked every cycle.
  - Output register: de <= de_d; hsync_n <= ~hs_d; vsync_n <= ~vs_d.
  - Colour: {red,green,blue} <= de_d ? {red_in,green_in,blue_in} : 0.
  - Total latency from counter value to panel pins = PIPE_DLY+1 clocks.
  - The input RGB sampled is the renderer output for the counter value PIPE_DLY clocks earlier.
- Widths and wrap: x_cnt and y_cnt never exceed H_TOTAL-1 and V_TOTAL-1. frame_cnt wraps modulo 256.
- Entering IDLE: the pipeline drains naturally. de stays 0 after at most PIPE_DLY+1 clocks, and RGB is black.

Test Plan:
- Reset release with run=1 held -> cycle 1 after release: x=0, y=0, frame_start=1. First de=1 at cycle 1+PIPE_DLY+1 = 4 (PIPE_DLY=2). de high for exactly 800 clocks per line.
- Free run of 2 frames -> hsync_n low for 48 clocks starting 840 clocks after line start. vsync_n low for 3 lines (3168 clocks) starting at line 493. Line period 1056, frame period 554400 clocks. frame_cnt = 2.
- Drive red_in=green_in=blue_in=8'hFF constantly -> RGB out = FF only while de=1, 0 during all porches and syncs.
- Deassert run at pixel (100,200) -> counting continues to (1055,524). Counters then park at (0,0), state IDLE, frame_cnt +1, no further frame_start. Reassert run -> frame_start on the next cycle.
- Deassert then reassert run within the same frame -> no counter discontinuity, frame_start at the normal frame boundary.
- Assert reset asynchronously at (400,300) between clock edges -> all outputs at reset values immediately. Restart from (0,0) on release.
